pc_update: RTL and testbench

- Program-counter register and next-PC selector for the sequential Y86-64 processor.
- Sits at the end of the datapath.
  - Consumes icode from fetch, cnd from execute, valC/valP from fetch, valM from memory.
  - Registers the selected next PC on the clock edge; fetch reads PC in the following cycle.

---
 rtl/pc_update.sv | 76 +++++++
 tb/tb_pc_update.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_update.sv
// Y86-64 program counter register with combinational next-PC selection and sticky halt.
// Optional macro PC_UPDATE_ICODE_CHECK_EN: treats icode 0xC-0xF as invalid and adds the invalid port.
module pc_update #(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    output logic [PC_WIDTH-1:0] PC,
    input  logic [3:0]          icode,
    input  logic                cnd,
    input  logic [PC_WIDTH-1:0] valC,
    input  logic [PC_WIDTH-1:0] valM,
    input  logic [PC_WIDTH-1:0] valP,
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    output logic [PC_WIDTH-1:0] next_pc,
    output logic                halted
`ifdef PC_UPDATE_ICODE_CHECK_EN
    ,
    output logic                invalid
`endif
);

    localparam logic [3:0] ICODE_HALT = 4'h0;
    localparam logic [3:0] ICODE_JXX  = 4'h7;
    localparam logic [3:0] ICODE_CALL = 4'h8;
    localparam logic [3:0] ICODE_RET  = 4'h9;

    logic [PC_WIDTH-1:0] r_pc;
    logic                r_halted;
    logic                w_invalid;
    logic                w_stop;

`ifdef PC_UPDATE_ICODE_CHECK_EN
    assign w_invalid = icode[3] & icode[2];
    assign invalid   = w_invalid;
`else
    assign w_invalid = 1'b0;
`endif

    // Both halt and an invalid opcode freeze the PC and latch the sticky halt flag.
    assign w_stop = (icode == ICODE_HALT) || w_invalid;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_pc = valP;
        if (w_invalid) begin
            next_pc = r_pc;
        end else begin
            case (icode)
                ICODE_CALL: next_pc = valC;
                ICODE_JXX:  next_pc = cnd ? valC : valP;
                ICODE_RET:  next_pc = valM;
                default:    next_pc = valP;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
        end else if (!r_halted) begin
            if (w_stop) begin
                r_halted <= 1'b1;
            end else if (!stall) begin
                r_pc <= next_pc;
            end
        end
    end

    assign PC     = r_pc;
    assign halted = r_halted;

endmodule

// File: tb/tb_pc_update.sv
// Scoreboard bench for pc_update: driver pushes model expectations, monitor pops and compares.
// Honours PC_UPDATE_ICODE_CHECK_EN the same way as the design.
module tb_pc_update;

    logic [63:0] PC;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valC;
    logic [63:0] valM;
    logic [63:0] valP;
    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [63:0] next_pc;
    logic        halted;
`ifdef PC_UPDATE_ICODE_CHECK_EN
    logic        invalid;
`endif

    pc_update dut (
        .PC      (PC),
        .icode   (icode),
        .cnd     (cnd),
        .valC    (valC),
        .valM    (valM),
        .valP    (valP),
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (stall),
        .next_pc (next_pc),
        .halted  (halted)
`ifdef PC_UPDATE_ICODE_CHECK_EN
        ,
        .invalid (invalid)
`endif
    );

    typedef struct {
        logic [63:0] nxt;
        logic [63:0] pc;
        logic        halted;
        logic        inv;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] ref_pc;
    logic        ref_halted;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_invalid(input logic [3:0] ic);
`ifdef PC_UPDATE_ICODE_CHECK_EN
        return ic >= 4'hC;
`else
        return 1'b0;
`endif
    endfunction

    // Reference selection rule: call/taken-jump go to the target, ret to the popped word, else fall through.
    function automatic logic [63:0] model_next(input logic [3:0] ic, input logic c,
                                               input logic [63:0] vc, input logic [63:0] vm,
                                               input logic [63:0] vp, input logic [63:0] cur);
        if (model_invalid(ic)) return cur;
        if (ic == 4'h8) return vc;
        if (ic == 4'h7 && c) return vc;
        if (ic == 4'h9) return vm;
        return vp;
    endfunction

    // Called at a falling edge: drive one instruction, predict its effect, hand off to the monitor.
    task automatic issue(input logic [3:0] ic, input logic c, input logic [63:0] vc,
                         input logic [63:0] vm, input logic [63:0] vp, input logic st);
        exp_t e;
        icode = ic;
        cnd   = c;
        valC  = vc;
        valM  = vm;
        valP  = vp;
        stall = st;
        e.nxt = model_next(ic, c, vc, vm, vp, ref_pc);
        e.inv = model_invalid(ic);
        if (!ref_halted) begin
            if (ic == 4'h0 || e.inv) ref_halted = 1'b1;
            else if (!st) ref_pc = e.nxt;
        end
        e.pc     = ref_pc;
        e.halted = ref_halted;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Called at a falling edge: assert reset between clock edges and check its immediate effect.
    task automatic reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        ref_pc     = 64'd0;
        ref_halted = 1'b0;
        check("async_reset_pc", PC, ref_pc);
        check("async_reset_halted", {63'd0, halted}, {63'd0, ref_halted});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (sb_q.size() > 0) begin
                e = sb_q[0];
                check("next_pc", next_pc, e.nxt);
`ifdef PC_UPDATE_ICODE_CHECK_EN
                check("invalid", {63'd0, invalid}, {63'd0, e.inv});
`endif
                @(posedge clk);
                #1;
                e = sb_q.pop_front();
                check("pc", PC, e.pc);
                check("halted", {63'd0, halted}, {63'd0, e.halted});
            end
        end
    end

    initial begin : driver
        logic [3:0] ic;
        rst_n      = 1'b0;
        ref_pc     = 64'd0;
        ref_halted = 1'b0;
        #1;
        check("reset_pc_idle_clk", PC, 64'd0);
        check("reset_halted_idle_clk", {63'd0, halted}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(4'h1, 1'b0, 64'd0, 64'd0, 64'd7, 1'b0);
        issue(4'h8, 1'b0, 64'd5, 64'd6, 64'd7, 1'b0);
        issue(4'h7, 1'b0, 64'd5, 64'd6, 64'd7, 1'b0);
        issue(4'h7, 1'b1, 64'd5, 64'd6, 64'd7, 1'b0);
        issue(4'h9, 1'b0, 64'd5, 64'd6, 64'd7, 1'b0);
        issue(4'h9, 1'b1, 64'd5, 64'd6, 64'd7, 1'b0);
        issue(4'h1, 1'b0, 64'd0, 64'd0, 64'd40, 1'b0);
        issue(4'h8, 1'b0, 64'd5, 64'd6, 64'd7, 1'b1);
        issue(4'hE, 1'b1, 64'd5, 64'd6, 64'd7, 1'b0);
        issue(4'h1, 1'b0, 64'd0, 64'd0, 64'd9, 1'b0);
        reset_mid();
        issue(4'h1, 1'b0, 64'd0, 64'd0, 64'd3, 1'b0);
        issue(4'h0, 1'b0, 64'd5, 64'd6, 64'd7, 1'b0);
        issue(4'h8, 1'b0, 64'd5, 64'd6, 64'd7, 1'b0);
        issue(4'h8, 1'b1, 64'd11, 64'd6, 64'd7, 1'b0);
        reset_mid();
        issue(4'h0, 1'b0, 64'd5, 64'd6, 64'd7, 1'b1);
        issue(4'h9, 1'b0, 64'd5, 64'd6, 64'd7, 1'b0);
        reset_mid();

        for (int n = 0; n < 400; n++) begin
            ic = 4'($urandom_range(0, 15));
            if (ic == 4'h0 && $urandom_range(0, 3) != 0) ic = 4'h6;
            issue(ic, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
            if (ref_halted && $urandom_range(0, 2) == 0) reset_mid();
        end

        @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
